prescaled_updown_counter: RTL and testbench
===========================================

Name: prescaled_updown_counter

Overview:
- Parametrised successor to the team's fixed 4-bit T-flip-flop counter with clock divider.
- Counts up or down modulo MODULUS, one step per prescaler tick.
- Runs in the single system clock domain: the divider produces a one-cycle tick enable, not a derived clock.
- Adds synchronous load, direction control, count enable, terminal-count and wrap flags.
- Sits between the board clock and the display/LED drivers in counter demos.

Parameters:
- WIDTH, 4: counter width in bits. Legal range is 1 to 32.
- MODULUS, 16: count modulus. q ranges from 0 to MODULUS-1. Legal range is 2 to 2^WIDTH.
- DIV, 50000000: prescaler period in clk cycles; one tick every DIV cycles. Legal range is 1 to 2^32-1. DIV=1 means a tick every enabled cycle.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: synchronous active-high reset.
- en, input, 1: count enable. Gates both the prescaler and the counter.
- up, input, 1: direction. 1 counts up, 0 counts down. Sampled on tick cycles.
- load, input, 1: synchronous load strobe.
- load_val, input, WIDTH: value loaded when load=1.
- q, output, WIDTH: current count, registered.
- tick, output, 1: registered one-cycle prescaler pulse.
- tc, output, 1: terminal count, combinational from q and up.
- wrap, output, 1: registered one-cycle pulse on the cycle after q wraps.

Behaviour:
- Reset (clk edge with reset=1):
  - q=0, prescaler=0, tick=0, wrap=0.
  - reset overrides load and en.
- Prescaler:
  - Internal counter psc of width ceil(log2(DIV)), minimum 1 bit.
  - When en=1: if psc==DIV-1, then psc<=0 and the tick pulse is generated; otherwise psc<=psc+1.
  - When en=0: psc holds and tick<=0.
  - tick is high for exactly one cycle per DIV enabled cycles.
  - First tick after reset comes DIV enabled cycles after reset releases.
- Count step, evaluated on the same edge that generates tick (internal tick_int):
  - up=1: if q==MODULUS-1, then q<=0 and wrap<=1; otherwise q<=q+1.
  - up=0: if q==0, then q<=MODULUS-1 and wrap<=1; otherwise q<=q-1.
  - Non-tick cycles: q holds and wrap<=0.
  - The output tick is asserted in the same cycle that q shows its new value.
- Load:
  - load=1 (reset=0): q<=load_val on that edge, regardless of en or tick.
  - Load has priority over a coincident count step.
  - wrap<=0 on a load edge.
  - load_val>MODULUS-1 is clamped to MODULUS-1.
  - Load does not touch psc, so tick phase is preserved.
- Priority: reset > load > count step > hold.
- tc = (up && q==MODULUS-1) || (!up && q==0).
  - Changes combinationally with up.
- Direction change mid-count:
  - Takes effect on the next tick; no extra step or skipped value.
- Non-power-of-two MODULUS:
  - q never exceeds MODULUS-1 in any path (reset, load, count).
- Arithmetic:
  - Unsigned, WIDTH bits.
  - MODULUS=2^WIDTH wraps naturally with no out-of-range state.

Test Plan:
- Reset mid-count:
  - Setup: WIDTH=4, MODULUS=16, DIV=4, en=1, up=1; run to q=9, then reset=1 for 1 cycle.
  - Required: next edge q=0, tick=0, wrap=0; first tick exactly 4 cycles after reset release; q=1 at that tick.
- Up wrap:
  - Setup: DIV=1, up=1, load 15, then count.
  - Required: tc=1 at q=15; next edge q=0 with wrap=1 for one cycle; then q=1 with wrap=0.
- Down, non-power-of-two modulus:
  - Setup: MODULUS=10, DIV=2, up=0, start q=0.
  - Required: tc=1; after 2 cycles q=9 with wrap=1; after 18 more cycles q=0.
  - Values 10 to 15 never appear.
- Load priority and clamp:
  - Setup: MODULUS=10, DIV=1; load=1 with load_val=13 on a tick cycle.
  - Required: q=9 (not 10, 13 or 14); wrap=0; psc phase unchanged.
- Enable gating:
  - Setup: DIV=4; drop en for 7 cycles after psc=2.
  - Required: q and psc hold and tick stays 0; after en returns, tick fires 2 cycles later.
- Direction flip:
  - Setup: DIV=1, q=5, up=1 toggled to 0 between ticks.
  - Required: sequence 5, 6, 5, 4; tc follows up combinationally (e.g. at q=0 with up toggled, tc goes 0 then 1).

Source files
------------

// File: rtl/prescaled_updown_counter.sv
// Up/down counter modulo MODULUS, stepped by a one-cycle prescaler tick.
// Single clock domain; the divider yields an enable, never a derived clock.
module prescaled_updown_counter #(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 16,
    parameter longint unsigned DIV     = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             tc,
    output logic             wrap
);

    localparam int              PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PMAX = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

    logic [PW-1:0]    psc;
    logic             tick_int;
    logic [WIDTH-1:0] q_step;
    logic             wrap_step;
    logic [WIDTH-1:0] q_load;

    assign tick_int = en && (psc == PMAX);
    assign tc       = up ? (q == MAXV) : (q == '0);
    assign q_load   = (load_val > MAXV) ? MAXV : load_val;

    always_comb begin
        q_step    = q;
        wrap_step = 1'b0;
        if (up) begin
            if (q == MAXV) begin
                q_step    = '0;
                wrap_step = 1'b1;
            end else begin
                q_step = q + WIDTH'(1);
            end
        end else begin
            if (q == '0) begin
                q_step    = MAXV;
                wrap_step = 1'b1;
            end else begin
                q_step = q - WIDTH'(1);
            end
        end
    end

    // Load leaves psc alone so the tick phase survives a reload.
    always_ff @(posedge clk) begin
        if (reset) begin
            psc  <= '0;
            tick <= 1'b0;
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            tick <= tick_int;
            if (en) begin
                psc <= tick_int ? '0 : psc + PW'(1);
            end
            if (load) begin
                q    <= q_load;
                wrap <= 1'b0;
            end else if (tick_int) begin
                q    <= q_step;
                wrap <= wrap_step;
            end else begin
                wrap <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Randomised and directed checks of four counter configurations
// against an arithmetic reference model.
module tb_prescaled_updown_counter;

    localparam int N = 4;
    localparam int MODS [N] = '{16, 16, 10, 10};
    localparam int DIVS [N] = '{4, 1, 2, 1};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] q    [N];
    logic       tick [N];
    logic       tc   [N];
    logic       wrap [N];

    int total = 0;
    int bad   = 0;

    int mq    [N];
    int ecnt  [N];
    int mtick [N];
    int mwrap [N];

    always #5 clk = ~clk;

    prescaled_updown_counter #(.WIDTH(4), .MODULUS(16), .DIV(4)) u0 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .q(q[0]), .tick(tick[0]), .tc(tc[0]),
        .wrap(wrap[0]));
    prescaled_updown_counter #(.WIDTH(4), .MODULUS(16), .DIV(1)) u1 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .q(q[1]), .tick(tick[1]), .tc(tc[1]),
        .wrap(wrap[1]));
    prescaled_updown_counter #(.WIDTH(4), .MODULUS(10), .DIV(2)) u2 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .q(q[2]), .tick(tick[2]), .tc(tc[2]),
        .wrap(wrap[2]));
    prescaled_updown_counter #(.WIDTH(4), .MODULUS(10), .DIV(1)) u3 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .q(q[3]), .tick(tick[3]), .tc(tc[3]),
        .wrap(wrap[3]));

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a tick every DIV enabled cycles since reset, modular step.
    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                mq[i] = 0; ecnt[i] = 0; mtick[i] = 0; mwrap[i] = 0;
            end else begin
                int t;
                t = 0;
                if (en) begin
                    ecnt[i]++;
                    t = (ecnt[i] % DIVS[i] == 0) ? 1 : 0;
                end
                mtick[i] = t;
                if (load) begin
                    mq[i] = (int'(load_val) > MODS[i] - 1) ?
                            MODS[i] - 1 : int'(load_val);
                    mwrap[i] = 0;
                end else if (t == 1) begin
                    if (up) begin
                        mwrap[i] = (mq[i] == MODS[i] - 1) ? 1 : 0;
                        mq[i] = (mq[i] + 1) % MODS[i];
                    end else begin
                        mwrap[i] = (mq[i] == 0) ? 1 : 0;
                        mq[i] = (mq[i] + MODS[i] - 1) % MODS[i];
                    end
                end else begin
                    mwrap[i] = 0;
                end
            end
        end
    endtask

    function automatic int exp_tc(input int i);
        if (up) return (mq[i] == MODS[i] - 1) ? 1 : 0;
        return (mq[i] == 0) ? 1 : 0;
    endfunction

    task automatic check_tc();
        for (int i = 0; i < N; i++)
            chk($sformatf("tc%0d", i), int'(tc[i]), exp_tc(i));
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("q%0d", i), int'(q[i]), mq[i]);
            chk($sformatf("tick%0d", i), int'(tick[i]), mtick[i]);
            chk($sformatf("wrap%0d", i), int'(wrap[i]), mwrap[i]);
        end
        check_tc();
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic cycn(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            mq[i] = 0; ecnt[i] = 0; mtick[i] = 0; mwrap[i] = 0;
        end
        // reset state
        cycn(2);
        chk("rst_q0", int'(q[0]), 0);
        chk("rst_tick0", int'(tick[0]), 0);

        // reset mid-count
        reset = 1'b0; en = 1'b1; up = 1'b1;
        cycn(36);
        chk("mid_q9", int'(q[0]), 9);
        reset = 1'b1;
        cyc();
        chk("mid_rst_q", int'(q[0]), 0);
        chk("mid_rst_tick", int'(tick[0]), 0);
        chk("mid_rst_wrap", int'(wrap[0]), 0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("mid_early_tick", int'(tick[0]), 0);
        end
        cyc();
        chk("mid_first_tick", int'(tick[0]), 1);
        chk("mid_first_q", int'(q[0]), 1);

        // down count, modulus 10, DIV 2
        reset = 1'b1;
        cyc();
        reset = 1'b0; up = 1'b0;
        #1;
        chk("dn_tc0", int'(tc[2]), 1);
        cycn(2);
        chk("dn_q9", int'(q[2]), 9);
        chk("dn_wrap", int'(wrap[2]), 1);
        cycn(18);
        chk("dn_q0", int'(q[2]), 0);

        // up wrap at DIV 1
        up = 1'b1; load = 1'b1; load_val = 4'd15;
        cyc();
        load = 1'b0;
        chk("uw_q15", int'(q[1]), 15);
        chk("uw_tc", int'(tc[1]), 1);
        cyc();
        chk("uw_q0", int'(q[1]), 0);
        chk("uw_wrap1", int'(wrap[1]), 1);
        cyc();
        chk("uw_q1", int'(q[1]), 1);
        chk("uw_wrap0", int'(wrap[1]), 0);

        // load clamp on a tick cycle
        load = 1'b1; load_val = 4'd13;
        cyc();
        load = 1'b0;
        chk("ld_clamp", int'(q[3]), 9);
        chk("ld_wrap", int'(wrap[3]), 0);
        chk("ld_noclamp", int'(q[0]), 13);

        // enable gating at psc=2 on DIV 4
        for (int k = 0; k < 4 && (ecnt[0] % 4) != 2; k++) cyc();
        chk("eg_phase", ecnt[0] % 4, 2);
        en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            cyc();
            chk("eg_hold_tick", int'(tick[0]), 0);
        end
        en = 1'b1;
        cyc();
        chk("eg_tick_early", int'(tick[0]), 0);
        cyc();
        chk("eg_tick", int'(tick[0]), 1);

        // direction flip at DIV 1
        load = 1'b1; load_val = 4'd5; up = 1'b1;
        cyc();
        load = 1'b0;
        chk("df_5", int'(q[1]), 5);
        cyc();
        chk("df_6", int'(q[1]), 6);
        up = 1'b0;
        cyc();
        chk("df_5b", int'(q[1]), 5);
        cyc();
        chk("df_4", int'(q[1]), 4);
        load = 1'b1; load_val = 4'd0; up = 1'b1;
        cyc();
        load = 1'b0; en = 1'b0;
        chk("df_tc_up", int'(tc[1]), 0);
        up = 1'b0;
        #1;
        chk("df_tc_dn", int'(tc[1]), 1);
        check_tc();

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            reset    = ($urandom_range(0, 99) == 0);
            en       = ($urandom_range(0, 9) != 0);
            load     = ($urandom_range(0, 29) == 0);
            load_val = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) up = ~up;
            #1;
            check_tc();
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
